// File: rtl/hazard_ctrl_if.sv
// -----------------------------------------------------------------------------
// hazard_ctrl_if
//   Bundles the signals between the pipeline datapath and the hazard/sequencing
//   controller. The controller connects through the slave modport. The pipeline
//   (or a testbench standing in for it) connects through the master modport.
//
//   Pipeline -> controller:
//     id_rs_num, id_rt_num   ID-stage source register numbers
//     id_use_rs, id_use_rt   ID instruction actually reads rs / rt
//     ex_ld, ex_regwrite     EX instruction is a load / writes a register
//     ex_write_num           EX destination register number
//     ex_redirect            EX resolved a taken branch or a jump
//     ex_halt                EX syscall requesting exit
//     mem_busy               data memory not ready this cycle
//   Controller -> pipeline:
//     pc_en, pc_redirect     PC load enable / PC mux selects the EX target
//     ifid_en .. memwb_en    pipeline register load enables
//     ifid_zero, idex_zero   pipeline register synchronous clears
//     halted                 core halted
//     stall_cnt, flush_cnt   statistics counters
// -----------------------------------------------------------------------------
interface hazard_ctrl_if #(
  parameter int REG_BITS = 6,
  parameter int CNT_BITS = 32
);
  logic [REG_BITS-1:0] id_rs_num;
  logic [REG_BITS-1:0] id_rt_num;
  logic                id_use_rs;
  logic                id_use_rt;
  logic                ex_ld;
  logic                ex_regwrite;
  logic [REG_BITS-1:0] ex_write_num;
  logic                ex_redirect;
  logic                ex_halt;
  logic                mem_busy;

  logic                pc_en;
  logic                pc_redirect;
  logic                ifid_en;
  logic                idex_en;
  logic                exmem_en;
  logic                memwb_en;
  logic                ifid_zero;
  logic                idex_zero;
  logic                halted;
  logic [CNT_BITS-1:0] stall_cnt;
  logic [CNT_BITS-1:0] flush_cnt;

  modport master (
    output id_rs_num, id_rt_num, id_use_rs, id_use_rt,
           ex_ld, ex_regwrite, ex_write_num, ex_redirect, ex_halt, mem_busy,
    input  pc_en, pc_redirect, ifid_en, idex_en, exmem_en, memwb_en,
           ifid_zero, idex_zero, halted, stall_cnt, flush_cnt
  );

  modport slave (
    input  id_rs_num, id_rt_num, id_use_rs, id_use_rt,
           ex_ld, ex_regwrite, ex_write_num, ex_redirect, ex_halt, mem_busy,
    output pc_en, pc_redirect, ifid_en, idex_en, exmem_en, memwb_en,
           ifid_zero, idex_zero, halted, stall_cnt, flush_cnt
  );
endinterface

// File: rtl/hazard_ctrl.sv
// -----------------------------------------------------------------------------
// hazard_ctrl
//   Hazard and sequencing controller for the 5-stage MIPS pipeline. It produces
//   the per-stage load enables and synchronous clears for PC, IF_ID, ID_EX,
//   EX_MEM and MEM_WB. It handles load-use stalls, taken-branch/jump flushes,
//   memory-busy freezes and the syscall halt. It also counts bubbles and
//   flushes for the statistics display.
//
//   Ports:
//     clk  system clock, all state updates on the rising edge
//     rst  synchronous active-high reset
//     bus  hazard_ctrl_if.slave (pipeline status in, enables/clears/counters out)
//
//   The enables and clears are combinational from the state and the inputs,
//   so the controller adds no latency. Only the state and the counters are
//   registered.
// -----------------------------------------------------------------------------
module hazard_ctrl #(
  parameter int REG_BITS = 6,
  parameter int CNT_BITS = 32
) (
  input  logic         clk,
  input  logic         rst,
  hazard_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    S_RESET_HOLD = 2'd0,
    S_RUN        = 2'd1,
    S_HALT       = 2'd2
  } state_t;

  state_t              r_state;
  state_t              w_next_state;
  logic [CNT_BITS-1:0] r_stall_cnt;
  logic [CNT_BITS-1:0] r_flush_cnt;
  logic                w_stall_inc;
  logic                w_flush_inc;

  logic [REG_BITS-1:0] w_ex_write_num;
  logic                w_rs_match;
  logic                w_rt_match;
  logic                w_lu;

  // Register 0 is hardwired to zero, so a load "into" r0 never creates a
  // dependency.
  assign w_ex_write_num = bus.ex_write_num;
  assign w_rs_match     = bus.id_use_rs && (w_ex_write_num == bus.id_rs_num);
  assign w_rt_match     = bus.id_use_rt && (w_ex_write_num == bus.id_rt_num);
  assign w_lu           = bus.ex_ld && bus.ex_regwrite && (w_ex_write_num != '0)
                          && (w_rs_match || w_rt_match);

  // NOTE: state and counters use non-blocking assignments so every flop
  // samples pre-edge values. Blocking here would create order-dependent races.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_RESET_HOLD;
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      r_state <= w_next_state;
      // Counters wrap naturally at 2^CNT_BITS.
      if (w_stall_inc) r_stall_cnt <= r_stall_cnt + CNT_BITS'(1);
      if (w_flush_inc) r_flush_cnt <= r_flush_cnt + CNT_BITS'(1);
    end
  end

  // NOTE: every output of this block gets a default before the case. Without
  // the defaults, any path that skips an assignment would infer a latch.
  always_comb begin
    w_next_state    = r_state;
    w_stall_inc     = 1'b0;
    w_flush_inc     = 1'b0;
    bus.pc_en       = 1'b0;
    bus.pc_redirect = 1'b0;
    bus.ifid_en     = 1'b0;
    bus.idex_en     = 1'b0;
    bus.exmem_en    = 1'b0;
    bus.memwb_en    = 1'b0;
    bus.ifid_zero   = 1'b0;
    bus.idex_zero   = 1'b0;
    bus.halted      = 1'b0;

    unique case (r_state)
      S_RESET_HOLD: begin
        // Hold the pipeline registers cleared until reset is released.
        bus.ifid_zero = 1'b1;
        bus.idex_zero = 1'b1;
        w_next_state  = S_RUN;
      end

      S_RUN: begin
        if (bus.ex_halt) begin
          // The halt beats a simultaneous busy or redirect. Freeze everything.
          w_next_state = S_HALT;
        end else if (bus.mem_busy) begin
          // Full freeze. A pending redirect or lu is re-evaluated once memory
          // is ready, so nothing is counted here.
        end else if (bus.ex_redirect) begin
          // The IF and ID instructions are wrong-path. Squash both. Any lu
          // hazard belongs to the squashed ID instruction and is ignored.
          bus.pc_en       = 1'b1;
          bus.pc_redirect = 1'b1;
          bus.ifid_en     = 1'b1;
          bus.idex_en     = 1'b1;
          bus.exmem_en    = 1'b1;
          bus.memwb_en    = 1'b1;
          bus.ifid_zero   = 1'b1;
          bus.idex_zero   = 1'b1;
          w_flush_inc     = 1'b1;
        end else if (w_lu) begin
          // Hold PC and IF_ID. Load a bubble into ID_EX. Let the load advance
          // to MEM, where forwarding covers it on the next cycle.
          bus.idex_en   = 1'b1;
          bus.idex_zero = 1'b1;
          bus.exmem_en  = 1'b1;
          bus.memwb_en  = 1'b1;
          w_stall_inc   = 1'b1;
        end else begin
          bus.pc_en    = 1'b1;
          bus.ifid_en  = 1'b1;
          bus.idex_en  = 1'b1;
          bus.exmem_en = 1'b1;
          bus.memwb_en = 1'b1;
        end
      end

      S_HALT: begin
        // Only reset leaves this state.
        bus.halted = 1'b1;
      end

      default: begin
        w_next_state = S_RESET_HOLD;
      end
    endcase
  end

  assign bus.stall_cnt = r_stall_cnt;
  assign bus.flush_cnt = r_flush_cnt;

endmodule

// File: tb/tb_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// tb_hazard_ctrl
//   Directed testbench for hazard_ctrl. The control outputs are packed as
//   {pc_en, pc_redirect, ifid_en, idex_en, exmem_en, memwb_en,
//    ifid_zero, idex_zero, halted}
//   and compared against hand-derived constants.
// -----------------------------------------------------------------------------
module tb_hazard_ctrl;

  localparam logic [8:0] O_RST  = 9'b000000110;  // reset hold
  localparam logic [8:0] O_RUN  = 9'b101111000;  // normal flow
  localparam logic [8:0] O_LU   = 9'b000111010;  // load-use bubble
  localparam logic [8:0] O_RED  = 9'b111111110;  // redirect flush
  localparam logic [8:0] O_FRZ  = 9'b000000000;  // busy / halt request
  localparam logic [8:0] O_HALT = 9'b000000001;  // halted

  logic clk;
  logic rst;
  int   n_total;
  int   n_pass;
  int   n_fail;

  hazard_ctrl_if #(.REG_BITS(6), .CNT_BITS(32)) bus ();

  hazard_ctrl #(.REG_BITS(6), .CNT_BITS(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  logic [8:0] outs;
  assign outs = {bus.pc_en, bus.pc_redirect, bus.ifid_en, bus.idex_en,
                 bus.exmem_en, bus.memwb_en, bus.ifid_zero, bus.idex_zero,
                 bus.halted};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one clock and settle just after the edge. Inputs set afterwards
  // are therefore far from the next active edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    bus.id_rs_num    = '0;
    bus.id_rt_num    = '0;
    bus.id_use_rs    = 1'b0;
    bus.id_use_rt    = 1'b0;
    bus.ex_ld        = 1'b0;
    bus.ex_regwrite  = 1'b0;
    bus.ex_write_num = '0;
    bus.ex_redirect  = 1'b0;
    bus.ex_halt      = 1'b0;
    bus.mem_busy     = 1'b0;
  endtask

  task automatic set_lu(input logic [5:0] wr, input logic [5:0] rs, input logic [5:0] rt,
                        input logic use_rs, input logic use_rt);
    bus.ex_ld        = 1'b1;
    bus.ex_regwrite  = 1'b1;
    bus.ex_write_num = wr;
    bus.id_rs_num    = rs;
    bus.id_rt_num    = rt;
    bus.id_use_rs    = use_rs;
    bus.id_use_rt    = use_rt;
  endtask

  initial begin
    n_total = 0;
    n_pass  = 0;
    n_fail  = 0;
    rst     = 1'b1;
    clear_inputs();

    // Reset held for three cycles.
    for (int i = 0; i < 3; i++) begin
      tick();
      check("rst_outs", 32'(outs), 32'(O_RST));
      check("rst_stall", bus.stall_cnt, 0);
      check("rst_flush", bus.flush_cnt, 0);
    end

    // Release. The FSM stays in RESET_HOLD for this cycle, then enters RUN.
    rst = 1'b0;
    #1 check("release_hold", 32'(outs), 32'(O_RST));
    tick();
    check("run_outs", 32'(outs), 32'(O_RUN));

    // Load-use on rs.
    set_lu(6'd8, 6'd8, 6'd3, 1'b1, 1'b0);
    #1 check("lu_rs_outs", 32'(outs), 32'(O_LU));
    tick();
    clear_inputs();
    #1 check("lu_rs_cnt", bus.stall_cnt, 1);
    check("lu_rs_after", 32'(outs), 32'(O_RUN));

    // A load into r0 never stalls.
    set_lu(6'd0, 6'd0, 6'd3, 1'b1, 1'b0);
    #1 check("lu_r0_outs", 32'(outs), 32'(O_RUN));
    tick();
    clear_inputs();
    #1 check("lu_r0_cnt", bus.stall_cnt, 1);

    // Load-use on rt.
    set_lu(6'd5, 6'd1, 6'd5, 1'b0, 1'b1);
    #1 check("lu_rt_outs", 32'(outs), 32'(O_LU));
    tick();
    clear_inputs();
    #1 check("lu_rt_cnt", bus.stall_cnt, 2);

    // Number matches, but the operand is not read, so there is no hazard.
    set_lu(6'd5, 6'd5, 6'd5, 1'b0, 1'b0);
    #1 check("lu_unused_outs", 32'(outs), 32'(O_RUN));
    // Not a register write, so there is no hazard.
    set_lu(6'd7, 6'd7, 6'd0, 1'b1, 1'b0);
    bus.ex_regwrite = 1'b0;
    #1 check("lu_norw_outs", 32'(outs), 32'(O_RUN));
    tick();
    clear_inputs();
    #1 check("lu_none_cnt", bus.stall_cnt, 2);

    // Redirect with a coincident load-use. The flush wins and is not counted as a stall.
    set_lu(6'd9, 6'd9, 6'd0, 1'b1, 1'b0);
    bus.ex_redirect = 1'b1;
    #1 check("red_lu_outs", 32'(outs), 32'(O_RED));
    tick();
    clear_inputs();
    #1 check("red_lu_flush", bus.flush_cnt, 1);
    check("red_lu_stall", bus.stall_cnt, 2);

    // Four cycles of mem_busy with redirect held, then the flush is taken.
    bus.ex_redirect = 1'b1;
    bus.mem_busy    = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1 check("busy_outs", 32'(outs), 32'(O_FRZ));
      tick();
      check("busy_flush", bus.flush_cnt, 1);
    end
    bus.mem_busy = 1'b0;
    #1 check("busy_end_outs", 32'(outs), 32'(O_RED));
    tick();
    check("busy_end_flush", bus.flush_cnt, 2);
    // Back-to-back redirect also counts.
    check("b2b_outs", 32'(outs), 32'(O_RED));
    tick();
    bus.ex_redirect = 1'b0;
    #1 check("b2b_flush", bus.flush_cnt, 3);

    // Halt coincident with busy and redirect. The halt wins.
    bus.ex_halt     = 1'b1;
    bus.mem_busy    = 1'b1;
    bus.ex_redirect = 1'b1;
    #1 check("halt_req_outs", 32'(outs), 32'(O_FRZ));
    tick();
    bus.ex_halt  = 1'b0;
    bus.mem_busy = 1'b0;
    set_lu(6'd4, 6'd4, 6'd4, 1'b1, 1'b1);
    for (int i = 0; i < 3; i++) begin
      #1 check("halt_outs", 32'(outs), 32'(O_HALT));
      tick();
      check("halt_flush", bus.flush_cnt, 3);
      check("halt_stall", bus.stall_cnt, 2);
    end

    // A reset pulse out of HALT. It takes effect at the next edge.
    rst = 1'b1;
    #1 check("halt_rst_pre", 32'(outs), 32'(O_HALT));
    tick();
    check("halt_rst_outs", 32'(outs), 32'(O_RST));
    check("halt_rst_stall", bus.stall_cnt, 0);
    check("halt_rst_flush", bus.flush_cnt, 0);
    rst = 1'b0;
    clear_inputs();
    tick();
    check("rerun_outs", 32'(outs), 32'(O_RUN));

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline hazard and sequencing controller for the 5-stage MIPS core. It generates the per-stage load-enable and synchronous-clear signals for PC, IF_ID, ID_EX, EX_MEM and MEM_WB, covering load-use stalls, taken-branch/jump flushes, memory-busy freezes and syscall halt. Stall and flush events are counted for the performance statistics display.

## Interface
Parameters:
- `REG_BITS`, 6, register-number width (matches `ReadRegister*Num` and `write`)
- `CNT_BITS`, 32, statistics counter width

Ports:
- `clk`  in  1  system clock; all state updates on posedge
- `rst`  in  1  synchronous, active-high reset
- `id_rs_num`  in  REG_BITS  ID-stage ReadRegister1Num
- `id_rt_num`  in  REG_BITS  ID-stage ReadRegister2Num
- `id_use_rs`  in  1  ID instruction reads rs
- `id_use_rt`  in  1  ID instruction reads rt
- `ex_ld`  in  1  EX-stage instruction is a load (ID_EX `ld_out`)
- `ex_regwrite`  in  1  ID_EX `RegWrite_out`
- `ex_write_num`  in  REG_BITS  ID_EX `write_out`
- `ex_redirect`  in  1  EX resolved a taken branch or any jump (Jmp/Jal/Jr)
- `ex_halt`  in  1  EX syscall with exit code (Syscall_out & v0==10)
- `mem_busy`  in  1  data memory not ready this cycle
- `pc_en`  out  1  PC register load enable
- `pc_redirect`  out  1  PC mux selects EX target
- `ifid_en`, `idex_en`, `exmem_en`, `memwb_en`  out  1 each  stage load enables (`idex_en` drives ID_EX `stall`, 1 = capture)
- `ifid_zero`, `idex_zero`  out  1 each  stage synchronous clears (drive `zero`)
- `halted`  out  1  core halted
- `stall_cnt`  out  CNT_BITS  load-use bubble cycles
- `flush_cnt`  out  CNT_BITS  redirect flush events

## Operation
- State machine: RESET_HOLD, RUN, HALT. Outputs combinational from state + inputs; state/counters registered.
- Load-use hazard `lu` = ex_ld & ex_regwrite & ex_write_num≠0 & ((id_use_rs & ex_write_num==id_rs_num) | (id_use_rt & ex_write_num==id_rt_num)).
- Priority in RUN, highest first:
  1. `ex_halt`: all enables 0, no clears; next state HALT.
  2. `mem_busy`: all enables 0, no clears, counters unchanged; redirect/lu re-evaluated next cycle.
  3. `ex_redirect`: pc_en=1, pc_redirect=1, ifid_zero=1, idex_zero=1, all enables 1; flush_cnt+1. Overrides `lu` (ID instruction is wrong-path).
  4. `lu`: pc_en=0, ifid_en=0, idex_zero=1 (bubble), exmem_en=memwb_en=1; stall_cnt+1.
  5. Otherwise all enables 1, clears 0, pc_redirect 0.
- HALT: all enables 0, clears 0, halted=1; exits only via `rst`.
- RESET_HOLD: entered while `rst`=1; all enables 0, ifid_zero=idex_zero=1, halted=0; next state RUN on first cycle with `rst`=0.
- Counters wrap modulo 2^CNT_BITS; never saturate.
- Zero-register number (0) never generates a hazard.

## Timing
- Reset: state=RESET_HOLD, stall_cnt=0, flush_cnt=0; while in reset pc_en=ifid_en=idex_en=exmem_en=memwb_en=0, pc_redirect=0, ifid_zero=idex_zero=1, halted=0.
- Rst asserted mid-operation (including HALT) takes effect at the next edge; counters clear same edge.
- Load-use: exactly one bubble per hazard; next cycle the load is in MEM and `lu` deasserts (forwarding covers it).
- Redirect: one cycle of clears; the two wrong-path instructions are squashed.
- Back-to-back redirects each count; a `lu` coincident with redirect does not increment stall_cnt.
- `ex_halt` coincident with `mem_busy` or `ex_redirect`: halt wins.
- Counter values are visible the cycle after the event.
- Zero added latency: no register between inputs and enable/clear outputs.

## Test plan
- Reset 3 cycles then release -> during reset all enables 0, zeros 1, counters 0; cycle after release state RUN, all enables 1.
- ex_ld=1, ex_regwrite=1, ex_write_num=8, id_rs_num=8, id_use_rs=1 for one cycle -> pc_en=0, ifid_en=0, idex_zero=1; stall_cnt 0->1.
- Same as previous but ex_write_num=0 -> no stall, stall_cnt stays 0.
- ex_redirect=1 with simultaneous load-use -> pc_redirect=1, ifid_zero=idex_zero=1, flush_cnt 0->1, stall_cnt unchanged.
- mem_busy=1 for 4 cycles with ex_redirect=1 held -> all enables 0 for 4 cycles, flush_cnt unchanged; cycle 5 flush taken, flush_cnt+1.
- ex_halt=1 one cycle -> halted=1 next cycle, enables 0 indefinitely despite other inputs; rst pulse -> RESET_HOLD then RUN, counters 0.
